// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: shared definitions for the multi-channel Wishbone timer.
//   - per-channel register offsets inside the 16-byte window
//   - CTRL bit positions
//   - channel and bus state encodings
//   - byte-lane merge helper for byte-select writes
package multi_timer_pkg;

    localparam logic [3:0] OFF_CTRL  = 4'h0;
    localparam logic [3:0] OFF_LOAD  = 4'h4;
    localparam logic [3:0] OFF_STAT  = 4'h8;
    localparam logic [3:0] OFF_START = 4'hC;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IE       = 2;

    typedef enum logic [1:0] {
        IDLE,
        COUNTING,
        DONE
    } chan_state_t;

    typedef enum logic [1:0] {
        WBIDLE,
        WBACCESS,
        WBACK
    } bus_state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/multi_timer_if.sv
// multi_timer_if: Wishbone classic request/response bundle for the timer.
//   cyc, stb, wen, adr[AW-1:0], sel[3:0], dat_w[31:0]  master -> slave
//   dat_r[31:0], ack                                   slave -> master
interface multi_timer_if #(
    parameter int AW = 6
);
    logic          cyc;
    logic          stb;
    logic          wen;
    logic [AW-1:0] adr;
    logic [3:0]    sel;
    logic [31:0]   dat_w;
    logic [31:0]   dat_r;
    logic          ack;

    modport master (
        output cyc, stb, wen, adr, sel, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, wen, adr, sel, dat_w,
        output dat_r, ack
    );
endinterface

// File: rtl/multi_timer_channel.sv
// multi_timer_channel: one timer channel (CTRL, LOAD, COUNT, PEND + FSM).
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_we_ctrl/load/stat/start  decoded single-cycle write strobes
//   i_sel, i_dat            byte enables and write data of the access
//   o_ctrl, o_load, o_count, o_pend   register contents for read-back
//   o_irq                   PEND & IE
//
//   state    | meaning
//   IDLE     | stopped, COUNT=0, waiting for START with EN=1
//   COUNTING | COUNT increments; COUNT==LOAD is an expiry
//   DONE     | one-shot expired, COUNT holds, waiting for START
module multi_timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we_ctrl,
    input  logic             i_we_load,
    input  logic             i_we_stat,
    input  logic             i_we_start,
    input  logic [3:0]       i_sel,
    input  logic [31:0]      i_dat,
    output logic [2:0]       o_ctrl,
    output logic [WIDTH-1:0] o_load,
    output logic [WIDTH-1:0] o_count,
    output logic             o_pend,
    output logic             o_irq
);

    chan_state_t      state;
    logic [2:0]       ctrl, ctrl_nxt;
    logic [WIDTH-1:0] load, load_nxt, count;
    logic             pend, expire, start, clr;

    always_comb begin
        ctrl_nxt = ctrl;
        if (i_we_ctrl && i_sel[0]) ctrl_nxt = i_dat[2:0];
        load_nxt = load;
        if (i_we_load) load_nxt = WIDTH'(merge_bytes(32'(load), i_dat, i_sel));
        start  = i_we_start && i_dat[0];
        clr    = i_we_stat && i_dat[0];
        expire = (state == COUNTING) && (count == load);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            ctrl  <= '0;
            load  <= '0;
            count <= '0;
            pend  <= 1'b0;
        end else begin
            ctrl <= ctrl_nxt;
            load <= load_nxt;
            // The incoming EN value is used so that disabling acts on the
            // same edge as the CTRL write.
            if (!ctrl_nxt[CTRL_EN]) begin
                state <= IDLE;
                count <= '0;
                pend  <= 1'b0;
            end else begin
                // Expiry beats a simultaneous W1C.
                if (expire)   pend <= 1'b1;
                else if (clr) pend <= 1'b0;
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= COUNTING;
                            count <= '0;
                        end
                    end
                    COUNTING: begin
                        if (start) begin
                            count <= '0;
                        end else if (expire) begin
                            if (ctrl[CTRL_PERIODIC]) count <= '0;
                            else                     state <= DONE;
                        end else begin
                            count <= count + WIDTH'(1);
                        end
                    end
                    DONE: begin
                        if (start) begin
                            state <= COUNTING;
                            count <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_ctrl  = ctrl;
    assign o_load  = load;
    assign o_count = count;
    assign o_pend  = pend;
    assign o_irq   = pend & ctrl[CTRL_IE];

endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_TIMERS-channel Wishbone timer peripheral.
//   i_clk, i_rst   clock, synchronous active-high reset
//   wb             Wishbone slave (multi_timer_if.slave), 16 bytes/channel
//   o_irq_vec      per-channel PEND & IE
//   o_irq          OR of o_irq_vec
// The bus side owns the access FSM, the address decode and the read mux.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_TIMERS = 4,
    parameter int WIDTH      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    multi_timer_if.slave          wb,
    output logic [NUM_TIMERS-1:0] o_irq_vec,
    output logic                  o_irq
);

    localparam int AW = $clog2(NUM_TIMERS) + 4;

    bus_state_t       bus_state;
    logic             wen_q;
    logic [AW-1:0]    adr_q;
    logic [3:0]       sel_q;
    logic [31:0]      dat_q;
    logic [31:0]      rd_mux;
    logic [AW-1:0]    chan_idx;
    logic [3:0]       off;
    logic             acc_wr;

    logic [2:0]       ch_ctrl  [NUM_TIMERS];
    logic [WIDTH-1:0] ch_load  [NUM_TIMERS];
    logic [WIDTH-1:0] ch_count [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] ch_pend;

    assign chan_idx = adr_q >> 4;
    assign off      = adr_q[3:0];
    assign acc_wr   = (bus_state == WBACCESS) && wen_q;

    // Out-of-range channel indices match no instance, so writes vanish and
    // reads fall through to zero without a separate range check.
    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
        logic hit;
        assign hit = acc_wr && (chan_idx == AW'(g));

        multi_timer_channel #(.WIDTH(WIDTH)) u_channel (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_we_ctrl  (hit && (off == OFF_CTRL)),
            .i_we_load  (hit && (off == OFF_LOAD)),
            .i_we_stat  (hit && (off == OFF_STAT)),
            .i_we_start (hit && (off == OFF_START)),
            .i_sel      (sel_q),
            .i_dat      (dat_q),
            .o_ctrl     (ch_ctrl[g]),
            .o_load     (ch_load[g]),
            .o_count    (ch_count[g]),
            .o_pend     (ch_pend[g]),
            .o_irq      (o_irq_vec[g])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (chan_idx == AW'(i)) begin
                case (off)
                    OFF_CTRL: rd_mux = {29'b0, ch_ctrl[i]};
                    OFF_LOAD: rd_mux = 32'(ch_load[i]);
                    // COUNT's top bit falls off the 31-bit field by the shift.
                    OFF_STAT: rd_mux = (32'(ch_count[i]) << 1) | {31'b0, ch_pend[i]};
                    default:  rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus_state <= WBIDLE;
            wen_q     <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
            wb.ack    <= 1'b0;
            wb.dat_r  <= '0;
        end else begin
            case (bus_state)
                WBIDLE: begin
                    if (wb.cyc && wb.stb && !wb.ack) begin
                        wen_q     <= wb.wen;
                        adr_q     <= wb.adr;
                        sel_q     <= wb.sel;
                        dat_q     <= wb.dat_w;
                        bus_state <= WBACCESS;
                    end
                end
                WBACCESS: begin
                    if (!wen_q) wb.dat_r <= rd_mux;
                    wb.ack    <= 1'b1;
                    bus_state <= WBACK;
                end
                WBACK: begin
                    wb.ack    <= 1'b0;
                    bus_state <= WBIDLE;
                end
                default: bus_state <= WBIDLE;
            endcase
        end
    end

    assign o_irq = |o_irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: randomized + directed bench for multi_timer.
// Main DUT: 4 channels, 32-bit. Second DUT: 3 channels, 16-bit, for
// out-of-range channel and width-truncation behaviour.
module tb_multi_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_timer_if #(.AW(6)) bus_a ();
    multi_timer_if #(.AW(6)) bus_b ();

    logic [3:0] irq_vec_a;
    logic       irq_a;
    logic [2:0] irq_vec_b;
    logic       irq_b;

    multi_timer #(.NUM_TIMERS(4), .WIDTH(32)) u_dut (
        .i_clk(clk), .i_rst(rst), .wb(bus_a), .o_irq_vec(irq_vec_a), .o_irq(irq_a));

    multi_timer #(.NUM_TIMERS(3), .WIDTH(16)) u_dut_s (
        .i_clk(clk), .i_rst(rst), .wb(bus_b), .o_irq_vec(irq_vec_b), .o_irq(irq_b));

    int n_vec = 0;
    int n_err = 0;
    int now   = 0;

    // Reference model: each channel run is described by its start edge,
    // its LOAD and mode; COUNT and PEND are derived arithmetically.
    logic [2:0] m_ctrl [4];
    int         m_load [4];
    bit         m_run  [4];
    int         m_t0   [4];
    int         m_rl   [4];
    bit         m_rp   [4];
    bit         m_pc   [4];   // pend carried over from before the current run
    int         m_clr  [4];   // edge of the most recent W1C

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %h expected %h", tag, now, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        now++;
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_ctrl[c] = 3'b000; m_load[c] = 0; m_run[c] = 0; m_t0[c] = 0;
            m_rl[c] = 0; m_rp[c] = 0; m_pc[c] = 0; m_clr[c] = -1;
        end
    endfunction

    // PEND after edge k: carried-over pend, or any expiry of the current run
    // that sets PEND at an edge s with last_clear <= s <= k.
    function automatic bit pend_at(input int ch, input int k);
        int s, l;
        if (m_pc[ch]) return 1'b1;
        if (!m_run[ch]) return 1'b0;
        l = m_rl[ch];
        s = m_t0[ch] + l + 1;
        if (m_clr[ch] > s) begin
            if (!m_rp[ch]) return 1'b0;
            s = s + ((m_clr[ch] - s + l) / (l + 1)) * (l + 1);
        end
        return s <= k;
    endfunction

    function automatic int count_at(input int ch, input int k);
        int d, l;
        if (!m_run[ch]) return 0;
        d = k - m_t0[ch];
        l = m_rl[ch];
        if (m_rp[ch]) return d % (l + 1);
        return (d < l) ? d : l;
    endfunction

    function automatic logic [31:0] rd_model(input int ch, input logic [3:0] off, input int k);
        case (off)
            4'h0:    return {29'b0, m_ctrl[ch]};
            4'h4:    return 32'(m_load[ch]);
            4'h8:    return (32'(count_at(ch, k)) << 1) | {31'b0, pend_at(ch, k)};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ack_of(input bit dut);
        return dut ? bus_b.ack : bus_a.ack;
    endfunction

    task automatic drive(input bit dut, input bit act, input bit wen, input logic [5:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
        if (!dut) begin
            bus_a.cyc = act; bus_a.stb = act; bus_a.wen = wen;
            bus_a.adr = adr; bus_a.sel = sel; bus_a.dat_w = dat;
        end else begin
            bus_b.cyc = act; bus_b.stb = act; bus_b.wen = wen;
            bus_b.adr = adr; bus_b.sel = sel; bus_b.dat_w = dat;
        end
    endtask

    // One Wishbone access; t_eff is the edge at which the register effect
    // and the ack appear.
    task automatic bus(input bit dut, input bit wen, input logic [5:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, output logic [31:0] rdat, output int t_eff);
        int  t_drv;
        bit  got;
        t_drv = now;
        got   = 0;
        t_eff = -1;
        rdat  = '0;
        drive(dut, 1'b1, wen, adr, sel, dat);
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (ack_of(dut)) begin
                got   = 1;
                t_eff = now;
                rdat  = dut ? bus_b.dat_r : bus_a.dat_r;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk("ack_latency", 32'(t_eff - t_drv), 32'd2);
        drive(dut, 1'b0, 1'b0, 6'h0, 4'h0, 32'h0);
        tick();
        chk("ack_single", 32'(ack_of(dut)), 32'd0);
    endtask

    task automatic wr_ch(input int ch, input logic [3:0] off, input logic [3:0] sel, input logic [31:0] dat);
        logic [31:0] rd, mask;
        int t;
        bus(1'b0, 1'b1, 6'(ch * 16 + int'(off)), sel, dat, rd, t);
        case (off)
            4'h0: if (sel[0]) begin
                m_ctrl[ch] = dat[2:0];
                if (!dat[0]) begin m_run[ch] = 0; m_pc[ch] = 0; end
            end
            4'h4: begin
                mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
                m_load[ch] = int'((32'(m_load[ch]) & ~mask) | (dat & mask));
            end
            4'h8: if (dat[0]) begin m_pc[ch] = 0; m_clr[ch] = t; end
            4'hC: if (dat[0] && m_ctrl[ch][0]) begin
                m_pc[ch]  = pend_at(ch, t);
                m_run[ch] = 1;
                m_t0[ch]  = t;
                m_rl[ch]  = m_load[ch];
                m_rp[ch]  = m_ctrl[ch][1];
            end
            default: ;
        endcase
    endtask

    task automatic rd_ch(input string tag, input int ch, input logic [3:0] off, output logic [31:0] rd);
        int t;
        bus(1'b0, 1'b0, 6'(ch * 16 + int'(off)), 4'hF, 32'h0, rd, t);
        chk(tag, rd, rd_model(ch, off, t - 1));
    endtask

    task automatic chk_irq();
        logic [3:0] e;
        for (int c = 0; c < 4; c++) e[c] = pend_at(c, now) & m_ctrl[c][2];
        chk("irq_vec", 32'(irq_vec_a), 32'(e));
        chk("irq", 32'(irq_a), 32'(|e));
    endtask

    task automatic program_ch(input int ch, input int load, input logic [2:0] ctrl);
        wr_ch(ch, 4'h0, 4'hF, 32'h0);
        wr_ch(ch, 4'h4, 4'hF, 32'(load));
        wr_ch(ch, 4'h0, 4'hF, {29'b0, ctrl});
        wr_ch(ch, 4'hC, 4'hF, 32'h1);
    endtask

    initial begin
        logic [31:0] rd;
        int t, t0, s0, t_rise;
        bit done;

        drive(1'b0, 1'b0, 1'b0, 6'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 6'h0, 4'h0, 32'h0);
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ack", 32'(bus_a.ack), 32'd0);
        chk("rst_dat", bus_a.dat_r, 32'h0);
        chk("rst_irq", 32'(irq_a), 32'd0);
        chk("rst_irq_vec", 32'(irq_vec_a), 32'd0);

        for (int c = 0; c < 4; c++)
            for (int o = 0; o < 16; o += 4) begin
                rd_ch("rst_reg", c, 4'(o), rd);
                chk("rst_reg_zero", rd, 32'h0);
            end

        // One-shot on ch0, LOAD=9.
        wr_ch(0, 4'h4, 4'hF, 32'd9);
        wr_ch(0, 4'h0, 4'hF, 32'h5);
        wr_ch(0, 4'hC, 4'hF, 32'h1);
        t0 = m_t0[0];
        t_rise = -1;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            chk_irq();
            if (irq_vec_a[0]) begin done = 1; t_rise = now; end
        end
        chk("oneshot_rise", 32'(t_rise - t0), 32'd10);
        repeat (5) tick();
        rd_ch("oneshot_stat", 0, 4'h8, rd);
        chk("oneshot_hold", rd, 32'h13);
        wr_ch(0, 4'h8, 4'hF, 32'h1);
        chk_irq();
        chk("oneshot_w1c_irq", 32'(irq_a), 32'd0);

        // Periodic ch2, LOAD=3: W1C on an expiry edge, then off one.
        program_ch(2, 3, 3'h7);
        s0 = m_t0[2] + 4;
        for (int i = 0; i < 8 && !((now + 2 >= s0) && ((now + 2 - s0) % 4 == 0)); i++) tick();
        wr_ch(2, 4'h8, 4'hF, 32'h1);
        rd_ch("per_stat_a", 2, 4'h8, rd);
        chk("w1c_set_wins", 32'(rd[0]), 32'd1);
        for (int i = 0; i < 8 && ((now + 2 - s0) % 4 != 1); i++) tick();
        wr_ch(2, 4'h8, 4'hF, 32'h1);
        rd_ch("per_stat_b", 2, 4'h8, rd);
        chk("w1c_clears", 32'(rd[0]), 32'd0);
        wr_ch(2, 4'h0, 4'hF, 32'h0);
        chk_irq();

        // Ch1 and ch3 concurrently, then IE masking on ch3.
        program_ch(1, 5, 3'h5);
        program_ch(3, 12, 3'h5);
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            chk_irq();
            if (irq_vec_a[1] && irq_vec_a[3]) done = 1;
        end
        chk("both_pend", 32'(irq_vec_a), 32'h0A);
        wr_ch(3, 4'h0, 4'hF, 32'h1);
        chk("ie_mask", 32'(irq_vec_a[3]), 32'd0);
        rd_ch("masked_stat", 3, 4'h8, rd);
        chk("masked_pend", 32'(rd[0]), 32'd1);
        wr_ch(1, 4'h8, 4'hF, 32'h1);
        chk("irq_after_ch1", 32'(irq_a), 32'd0);
        wr_ch(3, 4'h0, 4'hF, 32'h5);
        chk("irq_unmask", 32'(irq_a), 32'd1);
        wr_ch(3, 4'h8, 4'hF, 32'h1);
        chk("irq_after_ch3", 32'(irq_a), 32'd0);
        chk_irq();

        // EN=0 mid-count.
        program_ch(1, 20, 3'h7);
        repeat (25) tick();
        chk_irq();
        wr_ch(1, 4'h0, 4'hF, 32'h0);
        rd_ch("dis_stat", 1, 4'h8, rd);
        chk("dis_zero", rd, 32'h0);

        // Reset during a write transfer.
        program_ch(1, 20, 3'h7);
        repeat (5) tick();
        drive(1'b0, 1'b1, 1'b1, 6'h14, 4'hF, 32'h3);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_abort_ack0", 32'(bus_a.ack), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 6'h0, 4'h0, 32'h0);
        model_reset();
        tick();
        chk("rst_abort_ack1", 32'(bus_a.ack), 32'd0);
        tick();
        chk("rst_abort_ack2", 32'(bus_a.ack), 32'd0);
        rd_ch("rst_abort_stat", 1, 4'h8, rd);
        chk("rst_abort_zero", rd, 32'h0);
        rd_ch("rst_abort_load", 1, 4'h4, rd);
        chk_irq();

        // Randomized operations against the model.
        for (int n = 0; n < 250; n++) begin
            int ch, op;
            logic [2:0] cv;
            ch = int'($urandom_range(0, 3));
            op = int'($urandom_range(0, 6));
            case (op)
                0: begin
                    cv = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0};
                    wr_ch(ch, 4'h0, 4'hF, {29'b0, cv});
                    wr_ch(ch, 4'h4, 4'($urandom_range(1, 15)), 32'($urandom_range(0, 20)));
                    wr_ch(ch, 4'h0, 4'hF, {29'b0, cv | 3'b001});
                    wr_ch(ch, 4'hC, 4'hF, 32'h1);
                end
                1: wr_ch(ch, 4'hC, 4'hF, 32'($urandom_range(0, 1)));
                2: wr_ch(ch, 4'h8, 4'hF, 32'($urandom_range(0, 1)));
                3: begin
                    if (m_ctrl[ch][0]) cv = m_ctrl[ch] ^ 3'b100;
                    else               cv = {1'($urandom_range(0, 1)), 2'b00};
                    wr_ch(ch, 4'h0, 4'hF, {29'b0, cv});
                end
                4, 5: rd_ch("rand_read", ch, 4'(4 * $urandom_range(0, 3)), rd);
                default: wr_ch(ch, 4'h0, 4'hF, 32'h0);
            endcase
            chk_irq();
            repeat ($urandom_range(0, 4)) tick();
        end

        // Narrow DUT: width truncation, byte select, out-of-range channel.
        bus(1'b1, 1'b1, 6'h04, 4'hF, 32'hFFFF_1234, rd, t);
        bus(1'b1, 1'b0, 6'h04, 4'hF, 32'h0, rd, t);
        chk("narrow_load", rd, 32'h0000_1234);
        bus(1'b1, 1'b1, 6'h04, 4'h2, 32'h0000_AB99, rd, t);
        bus(1'b1, 1'b0, 6'h04, 4'hF, 32'h0, rd, t);
        chk("narrow_bytesel", rd, 32'h0000_AB34);
        bus(1'b1, 1'b1, 6'h34, 4'hF, 32'h5, rd, t);
        bus(1'b1, 1'b0, 6'h34, 4'hF, 32'h0, rd, t);
        chk("oor_load", rd, 32'h0);
        bus(1'b1, 1'b0, 6'h30, 4'hF, 32'h0, rd, t);
        chk("oor_ctrl", rd, 32'h0);
        bus(1'b1, 1'b0, 6'h04, 4'hF, 32'h0, rd, t);
        chk("oor_no_alias", rd, 32'h0000_AB34);
        chk("narrow_irq", 32'(irq_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
